// File: rtl/pll_bclksclkalign_multilane.sv
`default_nettype none
// ============================================================================
// Module  : pll_bclksclkalign_multilane
// Brief   : Multi-lane BCLK/SCLK alignment trainer that rotates the PLL VCO
//           phase until every enabled lane sees a BCLK rising edge.
// Revision: 1.0 - initial release
// ============================================================================
module pll_bclksclkalign_multilane #(
    parameter int IOG_FABRIC_RATIO = 2,
    parameter int NUM_LANES        = 1,
    parameter int MAX_ROTATE       = 72,
    parameter int CHECK_LEN        = 1023,
    parameter int SETTLE_CYC       = 4,
    parameter int RESET_CYC        = 31,
    parameter int RESET_EVERY      = 9,
    parameter int SKIP_EN          = 1,
    parameter int HOLD_EN          = 1
) (
    input  logic                                  sclk,
    input  logic                                  reset_n,
    input  logic                                  pll_bclksclkalign_train,
    input  logic                                  pll_clk_algn_rstrt,
    input  logic                                  pll_clk_algn_hold,
    input  logic                                  pll_clk_algn_skip,
    input  logic [NUM_LANES-1:0]                  lane_en,
    input  logic [NUM_LANES*IOG_FABRIC_RATIO-1:0] bclk_igear_rx,
    input  logic [2:0]                            vcophs_offset,
    output logic                                  vcophsel_bclk_sel,
    output logic                                  vcophsel_bclk90_sel,
    output logic                                  vcophsel_sclk_sel,
    output logic                                  vcophsel_mclk_sel,
    output logic                                  vcophsel_dir,
    output logic                                  vcophsel_rotate,
    output logic                                  loadphs_b,
    output logic [NUM_LANES-1:0]                  reset_lane,
    output logic                                  pll_bclksclkalign_done,
    output logic                                  pll_bclksclkalign_fail,
    output logic [6:0]                            apb_bclk0_vcophs_sel,
    output logic                                  apb_status_bclk,
    output logic [NUM_LANES-1:0]                  apb_lane_stuck
);
    localparam int C_R = IOG_FABRIC_RATIO;

    typedef enum logic [4:0] {
        S_IDLE = 5'd0,  S_RESE = 5'd1,  S_RESW = 5'd2,  S_LOAD = 5'd3,
        S_SETL = 5'd4,  S_CHEK = 5'd5,  S_EVAL = 5'd6,  S_ROTA = 5'd7,
        S_MRST = 5'd8,  S_MRSW = 5'd9,  S_RREG = 5'd10, S_OFFS = 5'd11,
        S_OFRT = 5'd12, S_PAUS = 5'd13, S_WAIT = 5'd14, S_DONE = 5'd15,
        S_FAIL = 5'd16, S_HOLD = 5'd17
    } state_t;

    state_t                      r_state, r_saved, w_state_nx, w_saved_nx;
    logic [2:0]                  r_skip_sync;
    logic [3:0]                  r_rstrt_sync;
    logic [1:0]                  r_stretch;
    logic                        w_skip, w_rstrt_rise, w_rst_trng, w_frz, w_all_seen;
    logic [4:0]                  r_dly;
    logic [9:0]                  r_chk;
    logic [6:0]                  r_rot, r_since;
    logic [2:0]                  r_off;
    logic [NUM_LANES*C_R-1:0]    r_rx_prev;
    logic [NUM_LANES-1:0]        r_seen, r_stuck, r_lane_stuck, w_rise, w_toggle;
    logic                        r_status;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_skip_sync  <= '0;
            r_rstrt_sync <= '0;
            r_stretch    <= '0;
        end else begin
            r_skip_sync  <= {r_skip_sync[1:0], pll_clk_algn_skip};
            r_rstrt_sync <= {r_rstrt_sync[2:0], pll_clk_algn_rstrt};
            if (w_rstrt_rise)
                r_stretch <= 2'd3;
            else if (r_stretch != 2'd0)
                r_stretch <= r_stretch - 2'd1;
        end
    end

    // Restart pulse = rising-edge cycle plus three stretched cycles.
    assign w_skip       = (SKIP_EN != 0) && r_skip_sync[2];
    assign w_rstrt_rise = r_rstrt_sync[2] & ~r_rstrt_sync[3];
    assign w_rst_trng   = w_rstrt_rise | (r_stretch != 2'd0) | w_skip;
    assign w_frz        = (r_state == S_HOLD) || ((HOLD_EN != 0) && pll_clk_algn_hold);
    assign w_all_seen   = (&(r_seen | ~lane_en)) && (|lane_en);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [C_R-1:0] w_cur, w_prv;
        assign w_cur       = bclk_igear_rx[k*C_R +: C_R];
        assign w_prv       = {w_cur[C_R-2:0], r_rx_prev[k*C_R + C_R - 1]};
        assign w_rise[k]   = |(w_cur & ~w_prv);
        assign w_toggle[k] = |(w_cur ^ w_prv);
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_saved <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
            r_saved <= w_saved_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_saved_nx = r_saved;
        if (w_rst_trng) begin
            w_state_nx = S_IDLE;
            w_saved_nx = S_IDLE;
        end else if ((HOLD_EN != 0) && pll_clk_algn_hold && (r_state != S_HOLD)) begin
            w_saved_nx = r_state;
            w_state_nx = S_HOLD;
        end else if (r_state == S_HOLD) begin
            if (!pll_clk_algn_hold) w_state_nx = r_saved;
        end else begin
            case (r_state)
                S_IDLE: if (pll_bclksclkalign_train) w_state_nx = S_RESE;
                S_RESE: w_state_nx = S_RESW;
                S_RESW: if (r_dly == 5'd0) w_state_nx = S_LOAD;
                S_LOAD: w_state_nx = S_SETL;
                S_SETL: if (r_dly == 5'd0) w_state_nx = S_CHEK;
                S_CHEK: if (r_chk == 10'(CHECK_LEN - 1)) w_state_nx = S_EVAL;
                S_EVAL: begin
                    if (w_all_seen)
                        w_state_nx = S_OFFS;
                    else if (r_rot == 7'(MAX_ROTATE))
                        w_state_nx = S_FAIL;
                    else if ((RESET_EVERY != 0) && (r_since == 7'(RESET_EVERY - 1)))
                        w_state_nx = S_MRST;
                    else
                        w_state_nx = S_ROTA;
                end
                S_ROTA: w_state_nx = S_SETL;
                S_MRST: w_state_nx = S_MRSW;
                S_MRSW: if (r_dly == 5'd0) w_state_nx = S_RREG;
                S_RREG: w_state_nx = S_ROTA;
                S_OFFS: w_state_nx = (r_off == vcophs_offset) ? S_PAUS : S_OFRT;
                S_OFRT: w_state_nx = S_OFFS;
                S_PAUS: w_state_nx = S_WAIT;
                S_WAIT: if (r_dly == 5'd0) w_state_nx = S_DONE;
                S_DONE, S_FAIL: if (!pll_bclksclkalign_train) w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_dly <= '0; r_chk <= '0; r_rot <= '0; r_since <= '0; r_off <= '0;
            r_rx_prev <= '0; r_seen <= '0; r_stuck <= '0; r_lane_stuck <= '0;
            r_status <= 1'b0;
        end else if (w_rst_trng) begin
            r_dly <= '0; r_chk <= '0; r_rot <= '0; r_since <= '0; r_off <= '0;
            r_rx_prev <= '0; r_seen <= '0; r_stuck <= '0; r_lane_stuck <= '0;
            r_status <= 1'b0;
        end else if (!w_frz) begin
            case (r_state)
                S_RESE: begin
                    r_dly    <= 5'(RESET_CYC);
                    r_status <= 1'b0;
                end
                S_RESW, S_MRSW: if (r_dly != 5'd0) r_dly <= r_dly - 5'd1;
                S_LOAD: begin
                    r_rot   <= '0;
                    r_since <= '0;
                    r_off   <= '0;
                    r_seen  <= '0;
                    r_stuck <= '1;
                    r_dly   <= 5'(SETTLE_CYC);
                end
                S_SETL: begin
                    if (r_dly != 5'd0) r_dly <= r_dly - 5'd1;
                    else               r_chk <= '0;
                end
                S_CHEK: begin
                    // The first window cycle only primes the history sample.
                    r_rx_prev <= bclk_igear_rx;
                    if (r_chk != 10'd0) begin
                        r_seen  <= r_seen | w_rise;
                        r_stuck <= r_stuck & ~w_toggle;
                    end
                    if (r_chk != 10'(CHECK_LEN - 1)) r_chk <= r_chk + 10'd1;
                end
                S_EVAL: begin
                    r_lane_stuck <= r_stuck;
                    r_seen       <= '0;
                    r_stuck      <= '1;
                end
                S_ROTA: begin
                    r_rot   <= r_rot + 7'd1;
                    r_since <= r_since + 7'd1;
                    r_dly   <= 5'(SETTLE_CYC);
                end
                S_MRST: begin
                    r_dly   <= 5'(RESET_CYC);
                    r_since <= '0;
                end
                S_RREG: r_rx_prev <= bclk_igear_rx;
                S_OFRT: r_off <= r_off + 3'd1;
                S_PAUS: r_dly <= 5'(SETTLE_CYC);
                S_WAIT: begin
                    if (r_dly != 5'd0) r_dly <= r_dly - 5'd1;
                    else               r_status <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign vcophsel_bclk_sel      = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL));
    assign vcophsel_bclk90_sel    = vcophsel_bclk_sel;
    assign vcophsel_sclk_sel      = 1'b0;
    assign vcophsel_mclk_sel      = 1'b0;
    assign vcophsel_dir           = 1'b1;
    assign vcophsel_rotate        = (r_state == S_ROTA) || (r_state == S_OFRT);
    assign loadphs_b              = (r_state != S_LOAD);
    assign reset_lane             = ((r_state == S_RESE) || (r_state == S_MRST) || (r_state == S_PAUS))
                                    ? lane_en : '0;
    assign pll_bclksclkalign_done = (r_state == S_DONE) || w_skip;
    assign pll_bclksclkalign_fail = (r_state == S_FAIL);
    assign apb_bclk0_vcophs_sel   = r_rot;
    assign apb_status_bclk        = r_status;
    assign apb_lane_stuck         = r_lane_stuck;
endmodule
`default_nettype wire

// File: tb/tb_pll_bclksclkalign_multilane.sv
`default_nettype none
// ============================================================================
// Module  : tb_pll_bclksclkalign_multilane
// Brief   : Directed table-driven bench with a phase-driven lane model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pll_bclksclkalign_multilane;
    localparam int C_R     = 4;
    localparam int C_LANES = 2;
    localparam int C_MAXR  = 20;
    localparam int C_RSTC  = 6;

    logic       sclk = 1'b0, reset_n = 1'b0, train = 1'b0, rstrt = 1'b0, hold = 1'b0, skip = 1'b0;
    logic [1:0] lane_en = 2'b00;
    logic [7:0] rx;
    logic [2:0] offset = 3'd0;
    logic       bclk_sel, bclk90_sel, sclk_sel, mclk_sel, dir, rotate, loadphs_b, done, fail, status;
    logic [1:0] reset_lane, lane_stuck;
    logic [6:0] phs_sel;

    int errors = 0, checks = 0;
    int ph = 0, lock0 = 99, lock1 = 99, cyc = 0;
    int rot_pulses = 0, rst_pulses = 0, rst_cyc = 0, gap = -1;
    bit after_rst = 1'b0;

    pll_bclksclkalign_multilane #(
        .IOG_FABRIC_RATIO(C_R), .NUM_LANES(C_LANES), .MAX_ROTATE(C_MAXR), .CHECK_LEN(16),
        .SETTLE_CYC(4), .RESET_CYC(C_RSTC), .RESET_EVERY(9), .SKIP_EN(1), .HOLD_EN(1)
    ) dut (
        .sclk(sclk), .reset_n(reset_n), .pll_bclksclkalign_train(train),
        .pll_clk_algn_rstrt(rstrt), .pll_clk_algn_hold(hold), .pll_clk_algn_skip(skip),
        .lane_en(lane_en), .bclk_igear_rx(rx), .vcophs_offset(offset),
        .vcophsel_bclk_sel(bclk_sel), .vcophsel_bclk90_sel(bclk90_sel),
        .vcophsel_sclk_sel(sclk_sel), .vcophsel_mclk_sel(mclk_sel), .vcophsel_dir(dir),
        .vcophsel_rotate(rotate), .loadphs_b(loadphs_b), .reset_lane(reset_lane),
        .pll_bclksclkalign_done(done), .pll_bclksclkalign_fail(fail),
        .apb_bclk0_vcophs_sel(phs_sel), .apb_status_bclk(status), .apb_lane_stuck(lane_stuck)
    );

    always #5 sclk = ~sclk;

    // A lane shows BCLK edges once the VCO phase reaches its lock phase.
    always_comb begin
        rx[3:0] = (ph >= lock0) ? 4'b0011 : 4'b0000;
        rx[7:4] = (ph >= lock1) ? 4'b0011 : 4'b0000;
    end

    always @(negedge sclk) begin
        cyc <= cyc + 1;
        if (!loadphs_b)  ph <= 0;
        else if (rotate) ph <= ph + 1;
        if (!train) begin
            rot_pulses <= 0;
            rst_pulses <= 0;
        end else begin
            if (rotate)      rot_pulses <= rot_pulses + 1;
            if (|reset_lane) rst_pulses <= rst_pulses + 1;
        end
        if (|reset_lane) begin
            rst_cyc   <= cyc;
            after_rst <= 1'b1;
        end else if (rotate && after_rst) begin
            gap       <= cyc - rst_cyc;
            after_rst <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_end();
        bit ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge sclk);
            if (done || fail) begin
                ok = 1'b1;
                break;
            end
        end
        chk("end_timeout", int'(ok), 1);
    endtask

    task automatic wait_rot(input int n);
        bit ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge sclk);
            if (rot_pulses >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rot_timeout", int'(ok), 1);
    endtask

    typedef struct {
        logic [1:0] en;
        int         l0, l1;
        logic [2:0] off;
        bit         e_done, e_fail;
        int         e_rot, e_rots, e_rsts;
        logic [1:0] e_stuck;
        bit         e_status;
    } vec_t;
    vec_t vt[6];

    initial begin
        vt[0] = '{2'b11, 5, 5,  3'd2, 1'b1, 1'b0, 5,  7,  2, 2'b00, 1'b1};
        vt[1] = '{2'b11, 5, 9,  3'd0, 1'b1, 1'b0, 9,  9,  3, 2'b00, 1'b1};
        vt[2] = '{2'b01, 5, 9,  3'd1, 1'b1, 1'b0, 5,  6,  2, 2'b10, 1'b1};
        vt[3] = '{2'b01, 0, 99, 3'd7, 1'b1, 1'b0, 0,  7,  2, 2'b10, 1'b1};
        vt[4] = '{2'b00, 0, 0,  3'd0, 1'b0, 1'b1, 20, 20, 0, 2'b00, 1'b0};
        vt[5] = '{2'b11, 99, 99, 3'd0, 1'b0, 1'b1, 20, 20, 3, 2'b11, 1'b0};

        repeat (3) @(negedge sclk);
        reset_n = 1'b1;
        @(negedge sclk);
        chk("rst_done", int'(done), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_loadphs_b", int'(loadphs_b), 1);
        chk("rst_dir", int'(dir), 1);
        chk("rst_sel", int'({bclk_sel, bclk90_sel, sclk_sel, mclk_sel, rotate}), 0);
        chk("rst_phs_sel", int'(phs_sel), 0);
        chk("rst_status", int'({status, lane_stuck, reset_lane}), 0);

        for (int i = 0; i < 6; i++) begin
            lane_en = vt[i].en;
            offset  = vt[i].off;
            lock0   = vt[i].l0;
            lock1   = vt[i].l1;
            train   = 1'b1;
            wait_end();
            @(negedge sclk);
            chk($sformatf("v%0d_done", i), int'(done), int'(vt[i].e_done));
            chk($sformatf("v%0d_fail", i), int'(fail), int'(vt[i].e_fail));
            chk($sformatf("v%0d_phs_sel", i), int'(phs_sel), vt[i].e_rot);
            chk($sformatf("v%0d_rotates", i), rot_pulses, vt[i].e_rots);
            chk($sformatf("v%0d_lane_resets", i), rst_pulses, vt[i].e_rsts);
            chk($sformatf("v%0d_stuck", i), int'(lane_stuck), int'(vt[i].e_stuck));
            chk($sformatf("v%0d_status", i), int'(status), int'(vt[i].e_status));
            chk($sformatf("v%0d_bclk_sel", i), int'(bclk_sel), 0);
            train = 1'b0;
            repeat (2) @(negedge sclk);
            chk($sformatf("v%0d_idle_low", i), int'({done, fail, bclk_sel, rotate}), 0);
        end
        // Periodic reset: MRST, RESET_CYC+1 MRSW cycles, RREG, then ROTA.
        chk("mrst_to_rotate_gap", gap, C_RSTC + 3);

        // Hold in the middle of a check window.
        lane_en = 2'b11; offset = 3'd0; lock0 = 5; lock1 = 5;
        train = 1'b1;
        wait_rot(2);
        repeat (8) @(negedge sclk);
        hold = 1'b1;
        repeat (50) @(negedge sclk);
        chk("hold_rotates_frozen", rot_pulses, 2);
        chk("hold_phs_sel", int'(phs_sel), 2);
        chk("hold_bclk_sel", int'(bclk_sel), 1);
        hold = 1'b0;
        wait_end();
        chk("hold_done", int'(done), 1);
        chk("hold_lock_phase", int'(phs_sel), 5);
        train = 1'b0;
        repeat (2) @(negedge sclk);

        // Restart during a settle wait.
        train = 1'b1;
        wait_rot(3);
        repeat (2) @(negedge sclk);
        rstrt = 1'b1;
        @(negedge sclk);
        rstrt = 1'b0;
        begin
            bit back = 1'b0;
            for (int c = 0; c < 7; c++) begin
                @(negedge sclk);
                if (phs_sel == 7'd0 && !bclk_sel) begin
                    back = 1'b1;
                    break;
                end
            end
            chk("restart_to_idle", int'(back), 1);
        end
        chk("restart_fail", int'(fail), 0);
        train = 1'b0;
        repeat (8) @(negedge sclk);

        // Skip bypass.
        train = 1'b1;
        skip  = 1'b1;
        repeat (2) @(negedge sclk);
        chk("skip_done_early", int'(done), 0);
        @(negedge sclk);
        chk("skip_done", int'(done), 1);
        repeat (10) @(negedge sclk);
        chk("skip_fsm_idle", int'({bclk_sel, rotate, phs_sel}), 0);
        skip = 1'b0;
        repeat (3) @(negedge sclk);
        chk("skip_release", int'(done), 0);
        train = 1'b0;
        repeat (2) @(negedge sclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
